inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Instruction encoder: the inverse of the core's immediate generator.
- Takes decoded fields (format, opcode, registers, funct, 32-bit immediate) and packs them into a 32-bit RV32I instruction word.
- Each word is tagged with a sequential instruction-memory byte address.
- Used by the instruction-memory loader and by the testbench to build programs for the single-cycle core. Valid/ready on both sides, 2-entry output buffer.

Parameters:
- ADDR_W, 32, width of out_addr.
- BASE_ADDR, 0, byte address assigned to the first emitted instruction after reset.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  field set presented
- in_ready  output  1  encoder can accept
- fmt  input  2  00=R, 01=I, 10=S, 11=reserved
- opcode  input  7  opcode field
- rd  input  5  destination register
- rs1  input  5  source register 1
- rs2  input  5  source register 2
- funct3  input  3  funct3
- funct7  input  7  funct7 (R only)
- imm  input  32  signed immediate (I/S)
- out_valid  output  1  out_inst/out_addr valid
- out_ready  input  1  consumer accepts
- out_inst  output  32  encoded instruction
- out_addr  output  ADDR_W  byte address of out_inst
- range_err  output  1  one-cycle pulse: accepted I/S imm not representable in 12 bits signed
- fmt_err  output  1  one-cycle pulse: accepted fmt=11

Behaviour:
- Reset (rst=1 at clock edge):
  - buffer emptied; out_valid=0, out_inst=0, out_addr=BASE_ADDR.
  - range_err=0, fmt_err=0; address counter=BASE_ADDR.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-transfer discards all buffered entries.
- Input accept: in_valid && in_ready at a clock edge.
- in_ready = (occupancy < 2). It depends only on registered occupancy, not combinationally on out_ready.
  - When full, a pop and a new accept cannot occur in the same cycle.
  - When occupancy is 1, simultaneous push and pop is legal and occupancy stays 1.
- Encoding, computed at accept and stored in the buffer:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}; rs2 and funct7 are ignored.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; rd and funct7 are ignored.
  - Opcode is passed through unchecked.
- Range check (I and S only): imm[31:11] must be all 0s or all 1s.
  - If violated: range_err=1 for the cycle after accept, and the word is still pushed using imm[11:0] (truncation).
- Reserved format: the entry is accepted (handshake completes) but not pushed; fmt_err=1 for the cycle after accept. No address is consumed.
- Latency: an entry accepted at edge N into an empty buffer gives out_valid=1 after edge N.
- Output side:
  - out_valid = (occupancy > 0).
  - out_inst and out_addr show the oldest entry.
  - Both are held stable while out_valid && !out_ready.
- Pop: out_valid && out_ready at a clock edge.
  - The address counter advances by 4 on each pop and wraps modulo 2^ADDR_W.
  - out_addr is the counter value, so addresses are contiguous in pop order.
- Round-trip property: for I and S words, feeding out_inst to the core's immediate generator returns sign-extend(imm[11:0]).
  - This requires opcode bit 5 = 0 for I and 1 for S.
- Buffer is a 2-entry FIFO: registered read/write pointers (1 bit each) and a 2-bit occupancy counter.

Test Plan:
- I-type: fmt=01, opcode=0010011, rd=5, rs1=6, funct3=000, imm=-1 → out_inst=0xFFF30293, out_addr=BASE_ADDR, range_err=0, latency 1 cycle.
- S-type: fmt=10, opcode=0100011, rs1=2, rs2=8, funct3=010, imm=0x7FC → out_inst=0x7E812E23; immediate generator on the result returns 0x000007FC.
- R-type then backpressure: push 3 words with out_ready=0 → in_ready drops after 2 accepts; third held. Raise out_ready → out_addr=BASE, BASE+4, BASE+8 in order; no loss or duplication.
- Range/format errors: I-type imm=0x800 → range_err pulse, word holds imm field 0x800 (reads -2048). fmt=11 → fmt_err pulse, nothing emitted, next word keeps the same address.
- Wrap: ADDR_W=4, BASE_ADDR=12, emit 2 words → out_addr 12, then 0.
- Reset mid-operation: buffer holding 2 words, assert rst one cycle → out_valid=0, in_ready=1. Next emitted word has out_addr=BASE_ADDR.

Source files
------------

// File: rtl/inst_encoder_if.sv
// Handshake bundle for inst_encoder: decoded field set in, encoded word and address out.
interface inst_encoder_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              range_err;
    logic              fmt_err;

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, range_err, fmt_err
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, out_inst, out_addr, range_err, fmt_err
    );
endinterface

// File: rtl/inst_encoder.sv
// Packs decoded R/I/S fields into RV32I instruction words, buffers them in a
// 2-entry FIFO and tags each popped word with a sequential byte address.
module inst_encoder #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    inst_encoder_if.slave bus
);
    localparam int unsigned DEPTH   = 2;
    localparam logic [1:0]  FMT_R   = 2'b00;
    localparam logic [1:0]  FMT_I   = 2'b01;
    localparam logic [1:0]  FMT_S   = 2'b10;
    localparam logic [1:0]  FMT_RSV = 2'b11;

    logic [31:0]       mem [DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        occ;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic              push;
    logic              pop;
    logic              imm_ovf;
    logic              has_imm;
    logic [31:0]       enc_word;

    // Ready depends only on registered occupancy, so a full buffer never pops and pushes together.
    assign bus.in_ready  = (occ != 2'(DEPTH));
    assign bus.out_valid = (occ != 2'd0);
    assign bus.out_inst  = mem[rd_ptr];
    assign bus.out_addr  = addr;

    assign accept  = bus.in_valid && bus.in_ready;
    assign push    = accept && (bus.fmt != FMT_RSV);
    assign pop     = bus.out_valid && bus.out_ready;
    assign has_imm = (bus.fmt == FMT_I) || (bus.fmt == FMT_S);
    // Immediate fits in 12 signed bits only when bits 31..11 are a pure sign extension.
    assign imm_ovf = !((&bus.imm[31:11]) || !(|bus.imm[31:11]));

    always_comb begin
        enc_word = 32'h0;
        case (bus.fmt)
            FMT_R:   enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            FMT_I:   enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
            FMT_S:   enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
            default: enc_word = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0]        <= 32'h0;
            mem[1]        <= 32'h0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            occ           <= 2'd0;
            addr          <= BASE_ADDR;
            bus.range_err <= 1'b0;
            bus.fmt_err   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= enc_word;
                wr_ptr      <= ~wr_ptr;
            end
            // The address is consumed at pop time, so dropped reserved entries never leave a gap.
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                addr   <= addr + ADDR_W'(4);
            end
            occ           <= occ + 2'(push) - 2'(pop);
            bus.range_err <= accept && has_imm && imm_ovf;
            bus.fmt_err   <= accept && (bus.fmt == FMT_RSV);
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// Randomised and directed bench for inst_encoder against a queue-based reference model.
module tb_inst_encoder;
    localparam int unsigned ADDR_W   = 32;
    localparam logic [31:0] BASE     = 32'h0000_0100;
    localparam int unsigned W_ADDR_W = 4;
    localparam logic [3:0]  W_BASE   = 4'd12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_encoder_if #(.ADDR_W(ADDR_W))   ifa ();
    inst_encoder_if #(.ADDR_W(W_ADDR_W)) ifw ();

    inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    inst_encoder #(.ADDR_W(W_ADDR_W), .BASE_ADDR(W_BASE)) dut_w (
        .clk(clk), .rst(rst), .bus(ifw)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr;
    logic        exp_rerr;
    logic        exp_ferr;

    // Word built from field weights (powers of two) rather than bit concatenation.
    function automatic logic [31:0] ref_encode(input logic [1:0] f, input logic [6:0] op,
                                               input logic [4:0] d, input logic [4:0] s1,
                                               input logic [4:0] s2, input logic [2:0] f3,
                                               input logic [6:0] f7, input logic [31:0] im);
        int unsigned lo12;
        int unsigned base;
        lo12 = im % 4096;
        base = 32'(s1) * 32768 + 32'(f3) * 4096 + 32'(op);
        case (f)
            2'b00:   return base + 32'(f7) * (1 << 25) + 32'(s2) * (1 << 20) + 32'(d) * 128;
            2'b01:   return base + lo12 * (1 << 20) + 32'(d) * 128;
            2'b10:   return base + (lo12 / 32) * (1 << 25) + 32'(s2) * (1 << 20) + (lo12 % 32) * 128;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit imm_fits(input logic [31:0] im);
        int v;
        v = signed'(im);
        return (v >= -2048) && (v <= 2047);
    endfunction

    // Core immediate generator view: opcode bit 5 selects S layout over I layout.
    function automatic int imm_gen(input logic [31:0] inst);
        int unsigned u;
        int unsigned raw;
        u = inst;
        if ((u / 32) % 2 == 1) raw = (u >> 25) * 32 + (u >> 7) % 32;
        else                   raw = u >> 20;
        return (raw >= 2048) ? int'(raw) - 4096 : int'(raw);
    endfunction

    task automatic drive(input logic v, input logic [1:0] f, input logic [6:0] op,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
        ifa.in_valid = v;  ifa.fmt = f;     ifa.opcode = op; ifa.rd = d;
        ifa.rs1 = s1;      ifa.rs2 = s2;    ifa.funct3 = f3; ifa.funct7 = f7;
        ifa.imm = im;
    endtask

    // Advance one clock, updating the model from the handshakes the edge will see.
    task automatic tick();
        bit acc;
        bit pp;
        acc = ifa.in_valid && (exp_q.size() < 2);
        pp  = ifa.out_ready && (exp_q.size() > 0);
        exp_rerr = 1'b0;
        exp_ferr = 1'b0;
        if (pp) begin
            void'(exp_q.pop_front());
            exp_addr += 4;
        end
        if (acc) begin
            if (ifa.fmt == 2'b11) exp_ferr = 1'b1;
            else begin
                exp_q.push_back(ref_encode(ifa.fmt, ifa.opcode, ifa.rd, ifa.rs1, ifa.rs2,
                                           ifa.funct3, ifa.funct7, ifa.imm));
                if (ifa.fmt != 2'b00 && !imm_fits(ifa.imm)) exp_rerr = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifa.in_valid = 1'b0;
        ifa.out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_addr = BASE;
        exp_rerr = 1'b0;
        exp_ferr = 1'b0;
    endtask

    task automatic drain();
        ifa.in_valid = 1'b0;
        ifa.out_ready = 1'b1;
        repeat (3) tick();
        ifa.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", ifa.out_valid); end
        checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", ifa.in_ready); end
        checks++; if (ifa.out_addr !== BASE) begin errors++; $display("FAIL reset_out_addr got %h exp %h", ifa.out_addr, BASE); end
        checks++; if (ifa.out_inst !== 32'h0) begin errors++; $display("FAIL reset_out_inst got %h exp 0", ifa.out_inst); end
        checks++; if ({ifa.range_err, ifa.fmt_err} !== 2'b00) begin errors++; $display("FAIL reset_errs got %b exp 00", {ifa.range_err, ifa.fmt_err}); end
    endtask

    task automatic test_i_type();
        drive(1'b1, 2'b01, 7'b0010011, 5'd5, 5'd6, 5'd17, 3'b000, 7'h55, 32'hFFFF_FFFF);
        tick();
        ifa.in_valid = 1'b0;
        checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL i_latency got %0b exp 1", ifa.out_valid); end
        checks++; if (ifa.out_inst !== 32'hFFF3_0293) begin errors++; $display("FAIL i_inst got %h exp fff30293", ifa.out_inst); end
        checks++; if (ifa.out_addr !== BASE) begin errors++; $display("FAIL i_addr got %h exp %h", ifa.out_addr, BASE); end
        checks++; if (ifa.range_err !== 1'b0) begin errors++; $display("FAIL i_range_err got %0b exp 0", ifa.range_err); end
        drain();
    endtask

    task automatic test_s_type();
        drive(1'b1, 2'b10, 7'b0100011, 5'd31, 5'd2, 5'd8, 3'b010, 7'h7F, 32'h0000_07FC);
        tick();
        ifa.in_valid = 1'b0;
        checks++; if (ifa.out_inst !== 32'h7E81_2E23) begin errors++; $display("FAIL s_inst got %h exp 7e812e23", ifa.out_inst); end
        checks++; if (imm_gen(ifa.out_inst) != 2044) begin errors++; $display("FAIL s_roundtrip got %0d exp 2044", imm_gen(ifa.out_inst)); end
        checks++; if (ifa.out_addr !== exp_addr) begin errors++; $display("FAIL s_addr got %h exp %h", ifa.out_addr, exp_addr); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rds[3];
        logic [4:0]  r1s[3];
        logic [4:0]  r2s[3];
        logic [2:0]  f3s[3];
        logic [6:0]  f7s[3];
        logic [31:0] w[3];
        logic [31:0] got_i[$];
        logic [31:0] got_a[$];
        int k = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rds[i] = 5'($urandom); r1s[i] = 5'($urandom); r2s[i] = 5'($urandom);
            f3s[i] = 3'($urandom); f7s[i] = 7'($urandom);
            w[i] = ref_encode(2'b00, 7'h33, rds[i], r1s[i], r2s[i], f3s[i], f7s[i], 32'h0);
        end
        for (int c = 0; c < 12 && (k < 3 || got_a.size() < 3); c++) begin
            if (c == 3) begin
                checks++; if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got %0b exp 0", ifa.in_ready); end
                checks++; if (k != 2) begin errors++; $display("FAIL bp_accepts got %0d exp 2", k); end
            end
            if (c == 4) ifa.out_ready = 1'b1;
            if (k < 3) drive(1'b1, 2'b00, 7'h33, rds[k], r1s[k], r2s[k], f3s[k], f7s[k], 32'($urandom));
            else ifa.in_valid = 1'b0;
            if (ifa.out_valid && ifa.out_ready) begin
                got_i.push_back(ifa.out_inst);
                got_a.push_back(ifa.out_addr);
            end
            if (ifa.in_valid && ifa.in_ready) k++;
            tick();
        end
        ifa.in_valid = 1'b0;
        checks++; if (got_a.size() != 3) begin errors++; $display("FAIL bp_pop_count got %0d exp 3", got_a.size()); end
        for (int i = 0; i < 3 && i < got_a.size(); i++) begin
            checks++; if (got_i[i] !== w[i]) begin errors++; $display("FAIL bp_inst%0d got %h exp %h", i, got_i[i], w[i]); end
            checks++; if (got_a[i] !== BASE + 32'(4 * i)) begin errors++; $display("FAIL bp_addr%0d got %h exp %h", i, got_a[i], BASE + 32'(4 * i)); end
        end
        checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b exp 0", ifa.out_valid); end
        ifa.out_ready = 1'b0;
    endtask

    task automatic test_errors();
        logic [31:0] a;
        drive(1'b1, 2'b01, 7'b0000011, 5'd9, 5'd10, 5'd0, 3'b010, 7'h0, 32'h0000_0800);
        tick();
        ifa.in_valid = 1'b0;
        checks++; if (ifa.range_err !== 1'b1) begin errors++; $display("FAIL range_pulse got %0b exp 1", ifa.range_err); end
        checks++; if (ifa.out_inst[31:20] !== 12'h800) begin errors++; $display("FAIL range_field got %h exp 800", ifa.out_inst[31:20]); end
        checks++; if (imm_gen(ifa.out_inst) != -2048) begin errors++; $display("FAIL range_value got %0d exp -2048", imm_gen(ifa.out_inst)); end
        tick();
        checks++; if (ifa.range_err !== 1'b0) begin errors++; $display("FAIL range_one_cycle got %0b exp 0", ifa.range_err); end
        drain();
        a = exp_addr;
        drive(1'b1, 2'b11, 7'h13, 5'd1, 5'd1, 5'd1, 3'b0, 7'h0, 32'h0);
        tick();
        ifa.in_valid = 1'b0;
        checks++; if (ifa.fmt_err !== 1'b1) begin errors++; $display("FAIL fmt_pulse got %0b exp 1", ifa.fmt_err); end
        checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL fmt_no_emit got %0b exp 0", ifa.out_valid); end
        tick();
        checks++; if (ifa.fmt_err !== 1'b0) begin errors++; $display("FAIL fmt_one_cycle got %0b exp 0", ifa.fmt_err); end
        drive(1'b1, 2'b01, 7'h13, 5'd2, 5'd3, 5'd0, 3'b0, 7'h0, 32'd7);
        tick();
        ifa.in_valid = 1'b0;
        checks++; if (ifa.out_addr !== a) begin errors++; $display("FAIL fmt_addr_kept got %h exp %h", ifa.out_addr, a); end
        drain();
    endtask

    task automatic test_random();
        logic [11:0] r;
        logic [31:0] im;
        for (int c = 0; c < 400; c++) begin
            checks++; if (ifa.in_ready !== (exp_q.size() < 2)) begin errors++; $display("FAIL rnd_in_ready c%0d got %0b", c, ifa.in_ready); end
            checks++; if (ifa.out_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL rnd_out_valid c%0d got %0b", c, ifa.out_valid); end
            if (exp_q.size() > 0) begin
                checks++; if (ifa.out_inst !== exp_q[0]) begin errors++; $display("FAIL rnd_inst c%0d got %h exp %h", c, ifa.out_inst, exp_q[0]); end
            end
            checks++; if (ifa.out_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr c%0d got %h exp %h", c, ifa.out_addr, exp_addr); end
            checks++; if ({ifa.range_err, ifa.fmt_err} !== {exp_rerr, exp_ferr}) begin errors++; $display("FAIL rnd_errs c%0d got %b exp %b", c, {ifa.range_err, ifa.fmt_err}, {exp_rerr, exp_ferr}); end
            r = 12'($urandom);
            im = ($urandom_range(0, 3) == 0) ? 32'($urandom) : {{20{r[11]}}, r};
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), 3'($urandom), 7'($urandom), im);
            ifa.out_ready = 1'($urandom_range(0, 2) != 0);
            tick();
        end
        drain();
    endtask

    task automatic test_wrap();
        logic [31:0] w0;
        logic [31:0] w1;
        w0 = ref_encode(2'b01, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5);
        w1 = ref_encode(2'b10, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, 32'hFFFF_FFF0);
        ifw.fmt = 2'b01; ifw.opcode = 7'h13; ifw.rd = 5'd1; ifw.rs1 = 5'd2; ifw.rs2 = 5'd0;
        ifw.funct3 = 3'd0; ifw.funct7 = 7'd0; ifw.imm = 32'd5; ifw.in_valid = 1'b1; ifw.out_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if (ifw.out_addr !== W_BASE) begin errors++; $display("FAIL wrap_first got %0d exp 12", ifw.out_addr); end
        checks++; if (ifw.out_inst !== w0) begin errors++; $display("FAIL wrap_inst0 got %h exp %h", ifw.out_inst, w0); end
        ifw.fmt = 2'b10; ifw.opcode = 7'h23; ifw.rd = 5'd0; ifw.rs1 = 5'd3; ifw.rs2 = 5'd4;
        ifw.funct3 = 3'd2; ifw.imm = 32'hFFFF_FFF0; ifw.out_ready = 1'b1;
        @(posedge clk); #1;
        ifw.in_valid = 1'b0;
        checks++; if (ifw.out_addr !== 4'd0) begin errors++; $display("FAIL wrap_second got %0d exp 0", ifw.out_addr); end
        checks++; if (ifw.out_inst !== w1) begin errors++; $display("FAIL wrap_inst1 got %h exp %h", ifw.out_inst, w1); end
        @(posedge clk); #1;
        checks++; if ({ifw.out_valid, ifw.out_addr} !== {1'b0, 4'd4}) begin errors++; $display("FAIL wrap_after got %b exp 00100", {ifw.out_valid, ifw.out_addr}); end
        ifw.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        ifa.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'b00, 7'h33, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), 32'h0);
            tick();
        end
        checks++; if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL rm_full got %0b exp 0", ifa.in_ready); end
        do_reset();
        checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid got %0b exp 0", ifa.out_valid); end
        checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got %0b exp 1", ifa.in_ready); end
        w = ref_encode(2'b01, 7'h13, 5'd4, 5'd7, 5'd0, 3'd1, 7'd0, 32'hFFFF_F800);
        drive(1'b1, 2'b01, 7'h13, 5'd4, 5'd7, 5'd0, 3'd1, 7'd0, 32'hFFFF_F800);
        tick();
        ifa.in_valid = 1'b0;
        checks++; if (ifa.out_addr !== BASE) begin errors++; $display("FAIL rm_addr got %h exp %h", ifa.out_addr, BASE); end
        checks++; if (ifa.out_inst !== w) begin errors++; $display("FAIL rm_inst got %h exp %h", ifa.out_inst, w); end
        drain();
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 2'b00, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
        ifa.out_ready = 1'b0;
        ifw.in_valid = 1'b0; ifw.out_ready = 1'b0; ifw.fmt = 2'b00; ifw.opcode = 7'h0;
        ifw.rd = 5'd0; ifw.rs1 = 5'd0; ifw.rs2 = 5'd0; ifw.funct3 = 3'd0; ifw.funct7 = 7'd0; ifw.imm = 32'h0;
        test_reset();
        test_wrap();
        test_i_type();
        test_s_type();
        test_back_to_back();
        test_errors();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
